// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the pipeline skid stage: payload defaults,
// the NOP instruction used as the bubble, and the occupancy encoding.
package pipe_skid_stage_pkg;

  // Natural width of one payload channel (PC or instruction word).
  localparam int DATA_LEN = 32;

  // add x0,x0,x0 -- the canonical RISC-V NOP, used as the bubble payload.
  localparam logic [DATA_LEN-1:0] NOP_INST = 32'h0000_0033;

  // Number of payload entries currently held by the stage.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // True while the stage still has a free entry for upstream.
  function automatic logic occ_has_room(input occ_e occ);
    return occ != OCC_TWO;
  endfunction

  // True while the stage holds at least one payload for downstream.
  function automatic logic occ_has_data(input occ_e occ);
    return occ != OCC_EMPTY;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter used for the stage's stall/flush statistics.
// Only built when PIPE_SKID_STAGE_PERF_EN is defined; without that macro
// the stage has no counters and this module is not needed at all.
`ifdef PIPE_SKID_STAGE_PERF_EN
module pipe_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  // Count one per cycle with inc_i high, stick at all-ones, clear on reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/pipe_skid_stage.sv
// Multi-channel pipeline register with valid/ready handshake and a
// two-entry skid buffer. Ready toward upstream depends only on the
// registered occupancy and stall, so back-pressure never forms a
// combinational path from dn_ready_i to up_ready_o.
// Optional stall/flush performance counters: define PIPE_SKID_STAGE_PERF_EN.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int                         DATA_W     = DATA_LEN,
  parameter int                         NUM_CH     = 2,
  parameter logic [NUM_CH*DATA_W-1:0]   BUBBLE_VAL = 64'h00000033_00000000,
  parameter int                         CNT_W      = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       up_valid_i,
  output logic                       up_ready_o,
  input  logic [NUM_CH*DATA_W-1:0]   up_data_i,
  output logic                       dn_valid_o,
  input  logic                       dn_ready_i,
  output logic [NUM_CH*DATA_W-1:0]   dn_data_o,
  input  logic                       stall_i,
  input  logic                       flush_i,
  output logic [1:0]                 occ_o,
  output logic [CNT_W-1:0]           stall_cnt_o,
  output logic [CNT_W-1:0]           flush_cnt_o
);

  occ_e                       occ_q;
  logic [NUM_CH*DATA_W-1:0]   head_q;
  logic [NUM_CH*DATA_W-1:0]   skid_q;
  logic                       up_fire;
  logic                       dn_fire;

  // Handshake decode: both sides freeze while stalled.
  assign up_ready_o = occ_has_room(occ_q) & ~stall_i;
  assign dn_valid_o = occ_has_data(occ_q) & ~stall_i;
  assign up_fire    = up_valid_i & up_ready_o;
  assign dn_fire    = dn_valid_o & dn_ready_i;

  assign dn_data_o  = head_q;
  assign occ_o      = occ_q;

  // Occupancy FSM plus head/skid payload registers; flush beats everything.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      occ_q  <= OCC_EMPTY;
      head_q <= BUBBLE_VAL;
      skid_q <= BUBBLE_VAL;
    end else if (flush_i) begin
      occ_q  <= OCC_EMPTY;
      head_q <= BUBBLE_VAL;
      skid_q <= BUBBLE_VAL;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (up_fire) begin
            head_q <= up_data_i;
            occ_q  <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (up_fire && dn_fire) begin
            head_q <= up_data_i;
          end else if (up_fire) begin
            skid_q <= up_data_i;
            occ_q  <= OCC_TWO;
          end else if (dn_fire) begin
            occ_q  <= OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (dn_fire) begin
            head_q <= skid_q;
            occ_q  <= OCC_ONE;
          end
        end
        default: begin
          occ_q <= OCC_EMPTY;
        end
      endcase
    end
  end

`ifdef PIPE_SKID_STAGE_PERF_EN
  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_i),
    .cnt_o (stall_cnt_o)
  );

  pipe_sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (flush_i),
    .cnt_o (flush_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Testbench for pipe_skid_stage: a FIFO-style reference model checked
// against the DUT every cycle, plus directed scenarios with literal
// expectations (reset, streaming, back-pressure, stall, flush, counters).
// A second instance with CNT_W=2 exercises counter saturation.
module tb_pipe_skid_stage;

  localparam logic [63:0] BUBBLE = 64'h00000033_00000000;
`ifdef PIPE_SKID_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        up_valid_i;
  logic        up_ready_o;
  logic [63:0] up_data_i;
  logic        dn_valid_o;
  logic        dn_ready_i;
  logic [63:0] dn_data_o;
  logic        stall_i;
  logic        flush_i;
  logic [1:0]  occ_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;

  logic        stall2;
  logic        up_ready2;
  logic        dn_valid2;
  logic [63:0] dn_data2;
  logic [1:0]  occ2;
  logic [1:0]  stall_cnt2;
  logic [1:0]  flush_cnt2;

  int num_checks = 0;
  int num_errors = 0;

  logic [63:0] model_q[$];
  logic [63:0] model_last;
  int          model_stall;
  int          model_flush;
  int          model_stall2;
  int          model_n;

  pipe_skid_stage dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .up_valid_i  (up_valid_i),
    .up_ready_o  (up_ready_o),
    .up_data_i   (up_data_i),
    .dn_valid_o  (dn_valid_o),
    .dn_ready_i  (dn_ready_i),
    .dn_data_o   (dn_data_o),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .occ_o       (occ_o),
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
  );

  pipe_skid_stage #(.CNT_W(2)) dut_sat (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .up_valid_i  (1'b0),
    .up_ready_o  (up_ready2),
    .up_data_i   (64'h0),
    .dn_valid_o  (dn_valid2),
    .dn_ready_i  (1'b0),
    .dn_data_o   (dn_data2),
    .stall_i     (stall2),
    .flush_i     (1'b0),
    .occ_o       (occ2),
    .stall_cnt_o (stall_cnt2),
    .flush_cnt_o (flush_cnt2)
  );

  // 10 time-unit clock.
  always #5 clk_i = ~clk_i;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    model_q.delete();
    model_last   = BUBBLE;
    model_stall  = 0;
    model_flush  = 0;
    model_stall2 = 0;
  endtask

  // One cycle: drive inputs just after a rising edge, hold them to the next.
  task automatic applyStimulus(input bit v, input logic [63:0] d, input bit r,
                               input bit s, input bit f);
    up_valid_i = v;
    up_data_i  = d;
    dn_ready_i = r;
    stall_i    = s;
    flush_i    = f;
    @(posedge clk_i);
    #1;
  endtask

  // Reference model: a bounded queue of at most two words, oldest first.
  always @(posedge clk_i) begin
    if (rst_i) begin
      model_n = model_q.size();
      if (stall_i) model_stall++;
      if (flush_i) model_flush++;
      if (stall2 && model_stall2 < 3) model_stall2++;
      if (flush_i) begin
        model_q.delete();
        model_last = BUBBLE;
      end else if (!stall_i) begin
        if (model_n > 0 && dn_ready_i) model_last = model_q.pop_front();
        if (model_n < 2 && up_valid_i) model_q.push_back(up_data_i);
      end
    end
  end

  // Compare DUT against the model mid-cycle on every cycle.
  always @(negedge clk_i) begin
    checkOutput("occ", {62'h0, occ_o}, 64'(model_q.size()));
    checkOutput("up_ready", {63'h0, up_ready_o}, {63'h0, (model_q.size() < 2) && !stall_i});
    checkOutput("dn_valid", {63'h0, dn_valid_o}, {63'h0, (model_q.size() > 0) && !stall_i});
    if (model_q.size() > 0) checkOutput("dn_data", dn_data_o, model_q[0]);
    else                    checkOutput("dn_data_idle", dn_data_o, model_last);
    checkOutput("stall_cnt", {32'h0, stall_cnt_o}, PERF ? 64'(model_stall) : 64'h0);
    checkOutput("flush_cnt", {32'h0, flush_cnt_o}, PERF ? 64'(model_flush) : 64'h0);
    checkOutput("stall_cnt_sat", {62'h0, stall_cnt2}, PERF ? 64'(model_stall2) : 64'h0);
  end

  initial begin
    rst_i      = 1'b0;
    up_valid_i = 1'b0;
    up_data_i  = '0;
    dn_ready_i = 1'b0;
    stall_i    = 1'b0;
    flush_i    = 1'b0;
    stall2     = 1'b0;
    modelReset();
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset_occ",   {62'h0, occ_o}, 64'd0);
    checkOutput("reset_valid", {63'h0, dn_valid_o}, 64'd0);
    checkOutput("reset_data",  dn_data_o, 64'h00000033_00000000);
    checkOutput("reset_ready", {63'h0, up_ready_o}, 64'd1);
    rst_i = 1'b1;

    // Streaming 0x10..0x1F with downstream always ready.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, {32'hA000_0000 + 32'(i), 32'h10 + 32'(i)}, 1'b1, 1'b0, 1'b0);
      if (i == 0) begin
        checkOutput("stream_first_data", dn_data_o, 64'hA0000000_00000010);
        checkOutput("stream_first_occ", {62'h0, occ_o}, 64'd1);
      end
    end
    checkOutput("stream_last_data", dn_data_o, 64'hA000000F_0000001F);
    checkOutput("stream_last_occ", {62'h0, occ_o}, 64'd1);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("stream_drained", {62'h0, occ_o}, 64'd0);

    // Back-pressure: A and B fill both entries.
    applyStimulus(1'b1, 64'h0000_00AA_0000_000A, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h0000_00BB_0000_000B, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_occ_full", {62'h0, occ_o}, 64'd2);
    checkOutput("bp_ready_low", {63'h0, up_ready_o}, 64'd0);
    checkOutput("bp_head_a", dn_data_o, 64'h0000_00AA_0000_000A);
    applyStimulus(1'b1, 64'h0000_00CC_0000_000C, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_head_b", dn_data_o, 64'h0000_00BB_0000_000B);
    checkOutput("bp_occ_one", {62'h0, occ_o}, 64'd1);
    applyStimulus(1'b1, 64'h0000_00CC_0000_000C, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_head_c", dn_data_o, 64'h0000_00CC_0000_000C);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_drained", {62'h0, occ_o}, 64'd0);

    // Stall for three cycles while holding one word.
    applyStimulus(1'b1, 64'h5555_0000_0000_0051, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 1'b1, 1'b0);
      checkOutput("stall_ready", {63'h0, up_ready_o}, 64'd0);
      checkOutput("stall_valid", {63'h0, dn_valid_o}, 64'd0);
      checkOutput("stall_hold", dn_data_o, 64'h5555_0000_0000_0051);
    end
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("stall_released", {62'h0, occ_o}, 64'd0);

    // Flush when full, with a word being offered: everything dropped.
    applyStimulus(1'b1, 64'h0000_0001_0000_00F1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h0000_0002_0000_00F2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h0000_0003_0000_00D0, 1'b0, 1'b0, 1'b1);
    checkOutput("flush_occ", {62'h0, occ_o}, 64'd0);
    checkOutput("flush_data", dn_data_o, 64'h00000033_00000000);

    // Flush and stall together: flush wins.
    applyStimulus(1'b1, 64'h0000_0004_0000_00F4, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h0000_0005_0000_00D5, 1'b1, 1'b1, 1'b1);
    checkOutput("flush_stall_occ", {62'h0, occ_o}, 64'd0);
    checkOutput("flush_stall_data", dn_data_o, 64'h00000033_00000000);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("perf_stall_cnt", {32'h0, stall_cnt_o}, PERF ? 64'd4 : 64'd0);
    checkOutput("perf_flush_cnt", {32'h0, flush_cnt_o}, PERF ? 64'd2 : 64'd0);

    // Reset in the middle of a transfer.
    applyStimulus(1'b1, 64'h0000_0006_0000_00E1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h0000_0007_0000_00E2, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b0;
    modelReset();
    #1;
    checkOutput("midrst_occ", {62'h0, occ_o}, 64'd0);
    checkOutput("midrst_valid", {63'h0, dn_valid_o}, 64'd0);
    checkOutput("midrst_data", dn_data_o, 64'h00000033_00000000);
    checkOutput("midrst_stall_cnt", {32'h0, stall_cnt_o}, 64'd0);
    up_valid_i = 1'b0;
    up_data_i  = '0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    applyStimulus(1'b1, 64'h0000_0008_0000_00E3, 1'b1, 1'b0, 1'b0);
    checkOutput("after_rst_data", dn_data_o, 64'h0000_0008_0000_00E3);
    checkOutput("after_rst_occ", {62'h0, occ_o}, 64'd1);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

    // Narrow counter saturation on the second instance.
    stall2 = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("sat_cnt_2", {62'h0, stall_cnt2}, PERF ? 64'd2 : 64'd0);
    checkOutput("sat_ready", {63'h0, up_ready2}, 64'd0);
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("sat_cnt_3", {62'h0, stall_cnt2}, PERF ? 64'd3 : 64'd0);
    checkOutput("sat_flush_cnt", {62'h0, flush_cnt2}, 64'd0);
    checkOutput("sat_occ", {62'h0, occ2}, 64'd0);
    checkOutput("sat_valid", {63'h0, dn_valid2}, 64'd0);
    checkOutput("sat_data", dn_data2, 64'h00000033_00000000);
    stall2 = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
    $finish;
  end

endmodule
